// File: rtl/unroller_if.sv
// unroller_if: narrow input beat stream and assembled wide vector stream
interface unroller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM = 8,
  parameter int ROLL_NUM = 2
);
  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM-1:0];
  logic data_in_valid;
  logic data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [NUM-1:0];
  logic data_out_valid;
  logic data_out_ready;
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input data_in_ready, data_out, data_out_valid
  );
  modport slave (
    input data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/unroller.sv
// unroller: gathers NUM/ROLL_NUM consecutive beats into one registered NUM-element vector
module unroller #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM = 8,
  parameter int ROLL_NUM = 2
) (
  input logic clk,
  input logic rst,
  unroller_if.slave bus
);
  localparam int CYCLES = NUM / ROLL_NUM;
  localparam int CW = $clog2(CYCLES) + 1;
  if (NUM % ROLL_NUM != 0) begin : g_bad_roll
    $error("unroller: NUM must be an integer multiple of ROLL_NUM");
  end
  logic [CW-1:0] cnt;
  logic [CW-1:0] slot;
  logic [DATA_WIDTH-1:0] vec [NUM-1:0];
  logic full;
  logic in_fire;
  logic out_fire;
  assign full = cnt == CW'(CYCLES);
  assign in_fire = bus.data_in_valid && bus.data_in_ready;
  assign out_fire = full && bus.data_out_ready;
  assign bus.data_out_valid = full;
  assign bus.data_in_ready = !full || bus.data_out_ready;
  assign bus.data_out = vec;
  // a beat arriving while the full vector drains starts the next vector at slot 0
  assign slot = full ? '0 : cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= out_fire ? (in_fire ? CW'(1) : '0) : (in_fire ? cnt + CW'(1) : cnt);
  for (genvar j = 0; j < NUM; j++) begin : g_el
    always_ff @(posedge clk)
      if (rst) vec[j] <= '0;
      else if (in_fire && slot == CW'(j / ROLL_NUM)) vec[j] <= bus.data_in[j % ROLL_NUM];
  end
endmodule

// File: tb/tb_unroller.sv
// tb_unroller: vector table, corner-case sequences and randomized queue-model check of unroller
module tb_unroller;
  localparam int DW = 16;
  localparam int N = 8;
  localparam int R = 2;
  localparam int VW = N * DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  unroller_if #(.DATA_WIDTH(DW), .NUM(N), .ROLL_NUM(R)) bus ();
  unroller_if #(.DATA_WIDTH(DW), .NUM(4), .ROLL_NUM(4)) bus4 ();
  unroller #(.DATA_WIDTH(DW), .NUM(N), .ROLL_NUM(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  unroller #(.DATA_WIDTH(DW), .NUM(4), .ROLL_NUM(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic v;
    int a;
    logic ordy;
    logic rdy;
    logic vld;
    int base;
  } row_t;
  row_t rows[$];
  logic [DW-1:0] cur[$];
  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, int a, logic ordy);
    bus.data_in_valid = v;
    bus.data_in[0] = DW'(a);
    bus.data_in[1] = DW'(a + 1);
    bus.data_out_ready = ordy;
  endtask
  function automatic logic [VW-1:0] got();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = bus.data_out[i];
    return r;
  endfunction
  function automatic logic [VW-1:0] seq(int base);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction
  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] r = '0;
    for (int i = 0; i < N && i < cur.size(); i++) r[i*DW +: DW] = cur[i];
    return r;
  endfunction
  function automatic logic [63:0] got4();
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*DW +: DW] = bus4.data_out[i];
    return r;
  endfunction
  initial begin
    logic [VW-1:0] exp_ab;
    logic [DW-1:0] rv [N];
    drive(1'b0, 0, 1'b0);
    bus4.data_in_valid = 1'b0;
    bus4.data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus4.data_in[i] = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset valid", VW'(bus.data_out_valid), VW'(0));
    chk("reset ready", VW'(bus.data_in_ready), VW'(1));
    chk("reset data", got(), '0);
    // fill, backpressure hold, release with same-cycle beat
    rows.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 3, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 5, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 7, 1'b1, 1'b1, 1'b1, 1});
    for (int k = 0; k < 5; k++) rows.push_back('{1'b1, 9, 1'b0, 1'b0, 1'b1, 1});
    rows.push_back('{1'b1, 9, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 11, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 13, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 15, 1'b1, 1'b1, 1'b1, 9});
    rows.push_back('{1'b0, 0, 1'b1, 1'b1, 1'b0, 0});
    // idle gap mid-fill
    rows.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 3, 1'b1, 1'b1, 1'b0, 0});
    for (int k = 0; k < 3; k++) rows.push_back('{1'b0, 0, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 5, 1'b1, 1'b1, 1'b0, 0});
    rows.push_back('{1'b1, 7, 1'b1, 1'b1, 1'b1, 1});
    rows.push_back('{1'b0, 0, 1'b1, 1'b1, 1'b0, 0});
    // twelve continuous beats 1..24
    for (int k = 0; k < 12; k++) rows.push_back('{1'b1, 2*k + 1, 1'b1, 1'b1, k % 4 == 3, (k / 4) * 8 + 1});
    rows.push_back('{1'b0, 0, 1'b1, 1'b1, 1'b0, 0});
    foreach (rows[n]) begin
      drive(rows[n].v, rows[n].a, rows[n].ordy);
      #1;
      chk($sformatf("row%0d ready", n), VW'(bus.data_in_ready), VW'(rows[n].rdy));
      step();
      chk($sformatf("row%0d valid", n), VW'(bus.data_out_valid), VW'(rows[n].vld));
      if (rows[n].vld) chk($sformatf("row%0d data", n), got(), seq(rows[n].base));
    end
    // reset mid-fill discards old beats
    drive(1'b1, 'h100, 1'b1);
    step();
    drive(1'b1, 'h102, 1'b1);
    step();
    rst = 1'b1;
    drive(1'b1, 'h104, 1'b1);
    step();
    rst = 1'b0;
    chk("midrst valid", VW'(bus.data_out_valid), VW'(0));
    chk("midrst data", got(), '0);
    drive(1'b1, 'hA, 1'b1);
    step();
    drive(1'b1, 'hC, 1'b1);
    step();
    drive(1'b1, 'hE, 1'b1);
    step();
    drive(1'b1, 'h10, 1'b1);
    step();
    exp_ab = {16'h11, 16'h10, 16'hF, 16'hE, 16'hD, 16'hC, 16'hB, 16'hA};
    chk("postrst valid", VW'(bus.data_out_valid), VW'(1));
    chk("postrst data", got(), exp_ab);
    drive(1'b0, 0, 1'b1);
    step();
    // reset while full and stalled
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2*k + 1, 1'b0);
      step();
    end
    chk("full stalled valid", VW'(bus.data_out_valid), VW'(1));
    rst = 1'b1;
    drive(1'b1, 'h55, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    #1;
    chk("fullrst valid", VW'(bus.data_out_valid), VW'(0));
    chk("fullrst ready", VW'(bus.data_in_ready), VW'(1));
    chk("fullrst data", got(), '0);
    // single-beat vectors: one register stage at full rate
    for (int k = 0; k < 2; k++) begin
      bus4.data_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) bus4.data_in[i] = DW'(4*k + i + 1);
      #1;
      chk($sformatf("deg%0d ready", k), VW'(bus4.data_in_ready), VW'(1));
      step();
      chk($sformatf("deg%0d valid", k), VW'(bus4.data_out_valid), VW'(1));
      chk($sformatf("deg%0d data", k), VW'(got4()),
          VW'({DW'(4*k + 4), DW'(4*k + 3), DW'(4*k + 2), DW'(4*k + 1)}));
    end
    bus4.data_in_valid = 1'b0;
    step();
    chk("deg idle valid", VW'(bus4.data_out_valid), VW'(0));
    // randomized traffic against an element-queue model
    cur.delete();
    for (int c = 0; c < 3000; c++) begin
      logic v, ordy, m_rdy, m_vld;
      v = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < R; i++) rv[i] = DW'($urandom);
      bus.data_in_valid = v;
      bus.data_in[0] = rv[0];
      bus.data_in[1] = rv[1];
      bus.data_out_ready = ordy;
      m_vld = cur.size() == N;
      m_rdy = !m_vld || ordy;
      #1;
      chk($sformatf("rnd%0d ready", c), VW'(bus.data_in_ready), VW'(m_rdy));
      chk($sformatf("rnd%0d valid", c), VW'(bus.data_out_valid), VW'(m_vld));
      if (m_vld) chk($sformatf("rnd%0d data", c), got(), model_vec());
      if (m_vld && ordy) cur.delete();
      if (v && m_rdy) for (int i = 0; i < R; i++) cur.push_back(rv[i]);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unroller.md
Name: unroller

Overview:
- Serial-to-parallel gatherer for the conv datapath.
- Accepts ROLL_NUM-element beats over a valid/ready handshake.
- Assembles CYCLES = NUM/ROLL_NUM consecutive beats into one NUM-element vector and presents it on a valid/ready output.
- Sits at the consumer end of a rolled (narrow) stream and restores full-width vectors for downstream parallel compute; sustains one beat per cycle with no bubble at vector boundaries.

Parameters:
- DATA_WIDTH, 16, bit width of each element.
- NUM, 8, elements in the assembled output vector.
- ROLL_NUM, 2, elements per input beat; NUM must be an integer multiple of ROLL_NUM (elaboration-time error otherwise).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- data_in  input  DATA_WIDTH x ROLL_NUM (unpacked [ROLL_NUM-1:0])  input beat.
- data_in_valid  input  1  beat valid.
- data_in_ready  output  1  beat accepted when valid and ready both high.
- data_out  output  DATA_WIDTH x NUM (unpacked [NUM-1:0])  assembled vector.
- data_out_valid  output  1  vector complete.
- data_out_ready  input  1  downstream accepts vector.

Behaviour:
- Derived value: CYCLES = NUM/ROLL_NUM.
- State: fill counter cnt, width $clog2(CYCLES)+1, range 0..CYCLES. Element buffer buf[NUM-1:0], which drives data_out directly (registered output, no combinational path from inputs).
- Reset values: cnt=0, all buf entries 0, data_out_valid=0, data_in_ready=1.
- Combinational outputs:
  - data_out_valid = (cnt == CYCLES).
  - data_in_ready = !data_out_valid || data_out_ready.
  - data_in_ready must not depend on data_in_valid.
- Events: in_fire = data_in_valid && data_in_ready; out_fire = data_out_valid && data_out_ready.
- Write placement:
  - On in_fire with cnt < CYCLES: buf[cnt*ROLL_NUM + i] <= data_in[i] for all i.
  - On in_fire while full (which implies out_fire): buf[i] <= data_in[i], i.e. slot 0.
- Ordering: element i of the k-th beat (k from 0) lands at data_out[k*ROLL_NUM + i]. The first beat occupies the lowest indices.
- Counter update, priority as listed:
  - out_fire && in_fire -> cnt = 1.
  - out_fire only -> cnt = 0.
  - in_fire only -> cnt = cnt + 1.
  - neither -> cnt unchanged.
- Latency: the final beat accepted at edge t gives data_out_valid=1 after edge t; the vector appears in the next cycle.
- Throughput: continuous input plus continuous data_out_ready gives one vector every CYCLES cycles with no idle cycle.
- Backpressure:
  - Full and data_out_ready=0 -> data_in_ready=0.
  - data_out and data_out_valid are held stable until out_fire.
- Simultaneous drain and fill: data_out shows the completed vector during the out_fire cycle. The incoming beat overwrites slot 0 only at the edge, so the presented vector is never corrupted.
- Partial-fill entries: indices at or above cnt*ROLL_NUM hold stale data from the previous vector (or 0 after reset). They are don't-care because valid is low and must not be cleared.
- Idle input: data_in_valid low mid-fill keeps cnt and buf unchanged indefinitely.
- Degenerate case ROLL_NUM == NUM (CYCLES=1): the block acts as a single-register pipeline stage with full throughput.
- Reset mid-fill or while full: partial or complete vector is discarded; cnt=0 and buf=0 on the next cycle.
- Reset has priority over all handshakes.

Test Plan (NUM=8, ROLL_NUM=2, DATA_WIDTH=16 unless noted):
- Reset then 4 back-to-back beats {1,2},{3,4},{5,6},{7,8}, data_out_ready=1 -> valid high one cycle after 4th accept; data_out[0..7]=1..8; data_in_ready stays 1 throughout.
- 12 continuous beats of values 1..24 with ready=1 -> two vectors 1..8 and 9..16 on consecutive 4-cycle boundaries, third vector 17..24 following; no cycle with data_in_ready=0.
- Full vector 1..8 with data_out_ready=0 for 5 cycles, data_in_valid=1 -> data_in_ready=0 and data_out stable at 1..8 for all 5 cycles. On release, the same-cycle beat {9,10} accepted and cnt=1.
- Beats {1,2},{3,4}, then data_in_valid=0 for 3 cycles, then {5,6},{7,8} -> valid only after 4th beat; output 1..8.
- Two beats accepted, assert rst one cycle, then beats {A,B},{C,D},{E,F},{10,11} -> output exactly A,B,C,D,E,F,10,11; pre-reset data never appears.
- NUM=4, ROLL_NUM=4: beats {1,2,3,4},{5,6,7,8} back-to-back with ready=1 -> vectors appear on consecutive cycles, one-cycle latency each.
